bcd_multi_digit_counter: RTL and testbench
==========================================

Name: bcd_multi_digit_counter

Overview:
- Parametrised multi-digit packed-BCD up/down counter for game timers, scores and countdowns (e.g. round timer, bomb fuse).
- Generalises the single-digit 9→0 down counter to:
  - NUM_DIGITS digits with ripple borrow/carry;
  - N-input enable AND;
  - a runtime up/down direction;
  - optional auto-reload;
  - a registered terminal pulse and a sticky done flag.
- Sits between the one-second/tick generators and the HUD/digit-display logic.

Parameters:
- NUM_DIGITS, 3, number of BCD digits; count width is 4*NUM_DIGITS.
- NUM_EN, 3, number of enable inputs; all must be 1 for a step.
- RESET_VALUE, 12'h300, packed BCD value loaded into count and reload_reg on reset; width 4*NUM_DIGITS.
- AUTO_RELOAD, 0, 1 = wrap at terminal; 0 = hold at terminal.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  synchronous load strobe, active-high.
- load_value  in  4*NUM_DIGITS  packed BCD value to load; digit 0 is in bits [3:0].
- enable  in  NUM_EN  step qualifiers; step = &enable.
- count_up  in  1  1 = count up, 0 = count down; sampled every cycle.
- count  out  4*NUM_DIGITS  current packed BCD value, registered.
- tc  out  1  combinational: count is at terminal for the current direction (all-0 when down, all-9 when up).
- tc_pulse  out  1  registered; high for one cycle after a step moves count onto terminal.
- done  out  1  sticky; set together with tc_pulse, cleared by load or reset.

Behaviour:
- Reset is synchronous and active-high: on a clk edge with reset=1:
  - count <= RESET_VALUE (sanitised);
  - reload_reg <= RESET_VALUE (sanitised);
  - tc_pulse <= 0;
  - done <= 0.
- Priority per cycle: reset > load > step > hold.
- Load:
  - count <= sanitise(load_value) and reload_reg <= sanitise(load_value);
  - tc_pulse <= 0 and done <= 0;
  - enable is ignored that cycle.
- Sanitise rule: any digit > 9 is replaced by 9; every other digit is unchanged.
- Step condition: step = &enable && !load && !reset. With no step, count, reload_reg and done hold, and tc_pulse <= 0.
- Down step, count != 0:
  - digit 0 decrements;
  - digit i decrements only if all digits below i are 0;
  - a decrementing digit at 0 becomes 9.
  - Example: 100 → 099.
- Down step, count == 0:
  - AUTO_RELOAD=1: count <= reload_reg;
  - AUTO_RELOAD=0: count holds at 0;
  - tc_pulse <= 0 in both cases; done is unchanged.
- Up step, count != all-9: mirror of the down rule (increment, 9→0 with carry). Example: 099 → 100.
- Up step, count == all-9:
  - AUTO_RELOAD=1: count <= 0;
  - AUTO_RELOAD=0: count holds at all-9.
- tc_pulse/done set: a step whose next count equals the terminal for the current direction sets tc_pulse <= 1 (one cycle) and done <= 1.
  - Reload/wrap steps do not set them.
- Direction change takes effect on the next step; no other side effect. tc follows count_up combinationally.
- Latency:
  - count updates one clk after the step/load cycle;
  - tc is valid in the same cycle as count;
  - tc_pulse is coincident with the first cycle count shows terminal.
- All arithmetic is per-digit 4-bit. No binary-to-BCD conversion and no multiplication.

Decomposition:
- Package bcd_counter_pkg contains:
  - typedef logic [3:0] bcd_digit_t;
  - localparam BCD_MAX = 4'd9;
  - function sanitise_digit(bcd_digit_t) returning bcd_digit_t.
- Sub-module bcd_digit_counter, one instance per digit, generated with a for-generate.
  - Inputs: clk, reset, reset_digit, load, load_digit, step_in (borrow/carry in), count_up, wrap_load, wrap_digit.
  - Outputs: digit, at_zero, at_nine.
  - The top level builds the ripple chain step_in[i] = step & all lower digits at boundary, plus the terminal/reload/done logic.

Test Plan (NUM_DIGITS=3, NUM_EN=3, RESET_VALUE=12'h300):
1. Reset and hold. Reset=1 for 1 cycle, then enable=3'b011 for 5 cycles → count=300, tc=0, done=0; count unchanged.
2. Down borrow to terminal (AUTO_RELOAD=0).
   - load 12'h101, then enable=3'b111 for 2 cycles → 100, then 099.
   - Continue 99 more steps → count=000 on that cycle with tc=1, tc_pulse=1 for exactly 1 cycle, done=1.
   - Further steps hold at 000 with no new tc_pulse.
3. Auto-reload (AUTO_RELOAD=1).
   - load 12'h002, then 3 steps → 001, 000 (tc_pulse), 002.
   - done stays 1 until the next load.
4. Up mode with invalid load.
   - load 12'h9A8 → count=998.
   - count_up=1, 1 step → 999, tc=1, tc_pulse=1.
   - Next step: AUTO_RELOAD=0 holds 999; AUTO_RELOAD=1 gives 000.
5. Priority and simultaneous events.
   - load=1, load_value=12'h050 with enable=3'b111 → count=050, no decrement.
   - reset=1 with load=1 → count=300, done=0.
   - Toggle count_up at 000 → tc drops to 0 combinationally; a step gives 001.

Source files
------------

// File: rtl/bcd_counter_pkg.sv
// Shared BCD digit type, digit limit and the digit sanitiser used by the
// multi-digit counter and its per-digit cells.
package bcd_counter_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Any non-decimal nibble (A-F) saturates to 9.
  function automatic bcd_digit_t sanitise_digit(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One packed-BCD digit: reset/load/wrap-load/step with up/down roll-over.
// Digit values arriving on reset_digit, load_digit and wrap_digit are already sanitised.
module bcd_digit_counter
  import bcd_counter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  bcd_digit_t reset_digit,
  input  logic       load,
  input  bcd_digit_t load_digit,
  input  logic       step_in,
  input  logic       count_up,
  input  logic       wrap_load,
  input  bcd_digit_t wrap_digit,
  output bcd_digit_t digit,
  output logic       at_zero,
  output logic       at_nine
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;

  assign at_zero = (digit_q == 4'd0);
  assign at_nine = (digit_q == BCD_MAX);
  assign digit   = digit_q;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_digit;
    end else if (wrap_load) begin
      digit_d = wrap_digit;
    end else if (step_in) begin
      if (count_up) begin
        digit_d = at_nine ? 4'd0 : digit_q + 4'd1;
      end else begin
        digit_d = at_zero ? BCD_MAX : digit_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= reset_digit;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/bcd_multi_digit_counter.sv
// Multi-digit packed-BCD up/down counter with ripple borrow/carry, optional
// auto-reload at terminal, a one-cycle terminal pulse and a sticky done flag.
module bcd_multi_digit_counter
  import bcd_counter_pkg::*;
#(
  parameter int                        NUM_DIGITS  = 3,
  parameter int                        NUM_EN      = 3,
  parameter logic [4*NUM_DIGITS-1:0]   RESET_VALUE = 'h300,
  parameter bit                        AUTO_RELOAD = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   load_value,
  input  logic [NUM_EN-1:0]         enable,
  input  logic                      count_up,
  output logic [4*NUM_DIGITS-1:0]   count,
  output logic                      tc,
  output logic                      tc_pulse,
  output logic                      done
);

  logic [4*NUM_DIGITS-1:0] reload_q;
  logic [4*NUM_DIGITS-1:0] reload_d;
  logic [4*NUM_DIGITS-1:0] load_san;
  logic [4*NUM_DIGITS-1:0] reset_san;
  logic                    tc_pulse_q;
  logic                    tc_pulse_d;
  logic                    done_q;
  logic                    done_d;

  bcd_digit_t              digit_w [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   at_zero;
  logic [NUM_DIGITS-1:0]   at_nine;
  logic [NUM_DIGITS-1:0]   step_in;

  logic step;
  logic at_term;
  logic wrap_load;
  logic upper_zero;
  logic upper_nine;
  logic hit_term;

  assign step      = (&enable) && !load && !reset;
  assign at_term   = count_up ? (&at_nine) : (&at_zero);
  assign wrap_load = step && at_term && AUTO_RELOAD;
  assign tc        = at_term;

  // Ripple chain: a terminal count never steps; it either holds or wrap-loads.
  assign step_in[0] = step && !at_term;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_chain
      assign step_in[gi] = step_in[gi-1] && (count_up ? at_nine[gi-1] : at_zero[gi-1]);
    end

    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign load_san[4*gi +: 4]  = sanitise_digit(load_value[4*gi +: 4]);
      assign reset_san[4*gi +: 4] = sanitise_digit(RESET_VALUE[4*gi +: 4]);
      assign count[4*gi +: 4]     = digit_w[gi];

      bcd_digit_counter u_digit (
        .clk         (clk),
        .reset       (reset),
        .reset_digit (reset_san[4*gi +: 4]),
        .load        (load),
        .load_digit  (load_san[4*gi +: 4]),
        .step_in     (step_in[gi]),
        .count_up    (count_up),
        .wrap_load   (wrap_load),
        .wrap_digit  (count_up ? 4'd0 : reload_q[4*gi +: 4]),
        .digit       (digit_w[gi]),
        .at_zero     (at_zero[gi]),
        .at_nine     (at_nine[gi])
      );
    end
  endgenerate

  always_comb begin
    upper_zero = 1'b1;
    upper_nine = 1'b1;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      upper_zero = upper_zero & at_zero[i];
      upper_nine = upper_nine & at_nine[i];
    end
  end

  // Next count lands on terminal: one below it in the current direction.
  assign hit_term = step && !at_term &&
                    (count_up ? (upper_nine && digit_w[0] == 4'd8)
                              : (upper_zero && digit_w[0] == 4'd1));

  always_comb begin
    reload_d   = load ? load_san : reload_q;
    tc_pulse_d = hit_term;
    done_d     = load ? 1'b0 : (done_q | hit_term);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reload_q   <= reset_san;
      tc_pulse_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      reload_q   <= reload_d;
      tc_pulse_q <= tc_pulse_d;
      done_q     <= done_d;
    end
  end

  assign tc_pulse = tc_pulse_q;
  assign done     = done_q;

endmodule

// File: tb/tb_bcd_multi_digit_counter.sv
// Scoreboard bench: two counters (hold and auto-reload) share one stimulus
// stream; expectations are queued per cycle and checked by a monitor.
module tb_bcd_multi_digit_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [11:0] load_value = 12'h000;
  logic [2:0]  enable = 3'b000;
  logic        count_up = 1'b0;

  logic [11:0] count0, count1;
  logic        tc0, tc1, tc_pulse0, tc_pulse1, done0, done1;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [11:0] c0; logic t0; logic p0; logic d0;
    logic [11:0] c1; logic t1; logic p1; logic d1;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  bcd_multi_digit_counter #(.NUM_DIGITS(3), .NUM_EN(3), .RESET_VALUE(12'h300), .AUTO_RELOAD(1'b0)) u_hold (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value), .enable(enable),
    .count_up(count_up), .count(count0), .tc(tc0), .tc_pulse(tc_pulse0), .done(done0)
  );

  bcd_multi_digit_counter #(.NUM_DIGITS(3), .NUM_EN(3), .RESET_VALUE(12'h300), .AUTO_RELOAD(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value), .enable(enable),
    .count_up(count_up), .count(count1), .tc(tc1), .tc_pulse(tc_pulse1), .done(done1)
  );

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string nm, input string fld, input logic [11:0] act, input logic [11:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s %s actual=%h required=%h", nm, fld, act, req);
    end
  endtask

  // Drive one cycle of inputs and queue what both counters must show after the edge.
  task automatic cyc2(input logic rst, input logic ld, input logic [11:0] lv, input logic [2:0] en,
                      input logic up,
                      input logic [11:0] c0, input logic t0, input logic p0, input logic d0,
                      input logic [11:0] c1, input logic t1, input logic p1, input logic d1,
                      input string nm);
    exp_t e;
    @(negedge clk);
    reset = rst; load = ld; load_value = lv; enable = en; count_up = up;
    e = '{c0: c0, t0: t0, p0: p0, d0: d0, c1: c1, t1: t1, p1: p1, d1: d1};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic cyc(input logic rst, input logic ld, input logic [11:0] lv, input logic [2:0] en,
                     input logic up, input logic [11:0] c, input logic t, input logic p, input logic d,
                     input string nm);
    cyc2(rst, ld, lv, en, up, c, t, p, d, c, t, p, d, nm);
  endtask

  // Monitor: every edge that has a queued expectation is compared.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        $display("txn %s: hold count=%h tc=%b p=%b d=%b | wrap count=%h tc=%b p=%b d=%b",
                 nm, count0, tc0, tc_pulse0, done0, count1, tc1, tc_pulse1, done1);
        chk(nm, "hold.count", count0, e.c0);
        chk(nm, "hold.tc", 12'(tc0), 12'(e.t0));
        chk(nm, "hold.tc_pulse", 12'(tc_pulse0), 12'(e.p0));
        chk(nm, "hold.done", 12'(done0), 12'(e.d0));
        chk(nm, "wrap.count", count1, e.c1);
        chk(nm, "wrap.tc", 12'(tc1), 12'(e.t1));
        chk(nm, "wrap.tc_pulse", 12'(tc_pulse1), 12'(e.p1));
        chk(nm, "wrap.done", 12'(done1), 12'(e.d1));
      end
    end
  end

  initial begin
    int guard;
    // 1. reset and hold with partial enable
    cyc(1, 0, 12'h000, 3'b000, 0, 12'h300, 0, 0, 0, "reset");
    for (int k = 0; k < 5; k++) cyc(0, 0, 12'h000, 3'b011, 0, 12'h300, 0, 0, 0, "hold_partial_en");

    // 2. down borrow to terminal
    cyc(0, 1, 12'h101, 3'b000, 0, 12'h101, 0, 0, 0, "load_101");
    cyc(0, 0, 12'h000, 3'b111, 0, 12'h100, 0, 0, 0, "down_100");
    cyc(0, 0, 12'h000, 3'b111, 0, 12'h099, 0, 0, 0, "down_borrow_099");
    for (int k = 98; k >= 0; k--)
      cyc(0, 0, 12'h000, 3'b111, 0, to_bcd(k), k == 0, k == 0, k == 0, "down_run");
    cyc2(0, 0, 12'h000, 3'b111, 0, 12'h000, 1, 0, 1, 12'h101, 0, 0, 1, "down_past_terminal");
    cyc2(0, 0, 12'h000, 3'b111, 0, 12'h000, 1, 0, 1, 12'h100, 0, 0, 1, "down_after_reload");

    // 3. short countdown with reload
    cyc(0, 1, 12'h002, 3'b111, 0, 12'h002, 0, 0, 0, "load_002");
    cyc(0, 0, 12'h000, 3'b111, 0, 12'h001, 0, 0, 0, "down_001");
    cyc(0, 0, 12'h000, 3'b111, 0, 12'h000, 1, 1, 1, "down_000_pulse");
    cyc2(0, 0, 12'h000, 3'b111, 0, 12'h000, 1, 0, 1, 12'h002, 0, 0, 1, "reload_002");
    cyc2(0, 0, 12'h000, 3'b111, 0, 12'h000, 1, 0, 1, 12'h001, 0, 0, 1, "done_sticky");

    // 4. up mode with invalid digits
    cyc(0, 1, 12'h9A8, 3'b000, 1, 12'h998, 0, 0, 0, "load_9A8_sanitised");
    cyc(0, 0, 12'h000, 3'b111, 1, 12'h999, 1, 1, 1, "up_999_pulse");
    cyc2(0, 0, 12'h000, 3'b111, 1, 12'h999, 1, 0, 1, 12'h000, 0, 0, 1, "up_past_terminal");
    cyc(0, 1, 12'hFB3, 3'b000, 0, 12'h993, 0, 0, 0, "load_FB3_sanitised");
    cyc(0, 1, 12'h099, 3'b000, 1, 12'h099, 0, 0, 0, "load_099");
    cyc(0, 0, 12'h000, 3'b111, 1, 12'h100, 0, 0, 0, "up_carry_100");

    // 5. priority and direction change
    cyc(0, 1, 12'h050, 3'b111, 0, 12'h050, 0, 0, 0, "load_beats_step");
    cyc(1, 1, 12'h123, 3'b111, 0, 12'h300, 0, 0, 0, "reset_beats_load");
    cyc(0, 1, 12'h000, 3'b000, 0, 12'h000, 1, 0, 0, "load_000_no_pulse");
    cyc(0, 0, 12'h000, 3'b111, 0, 12'h000, 1, 0, 0, "step_at_000_done_kept");
    cyc(0, 0, 12'h000, 3'b000, 1, 12'h000, 0, 0, 0, "dir_up_tc_drops");
    cyc(0, 0, 12'h000, 3'b111, 1, 12'h001, 0, 0, 0, "up_from_000");

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
